// File: rtl/counter_checker_pkg.sv
// counter_checker_pkg: shared state encoding, default widths and the +1 wrap helper.
package counter_checker_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} chk_state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_STAT_W = 16;
  function automatic logic [63:0] next_val(input logic [63:0] v, input int w);
    return (v + 64'd1) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/counter_checker_if.sv
// counter_checker_if: observed counter stream in, lock/error/statistics out.
interface counter_checker_if #(
  parameter int WIDTH = counter_checker_pkg::DEF_WIDTH,
  parameter int STAT_W = counter_checker_pkg::DEF_STAT_W
);
  logic en;
  logic clear;
  logic [WIDTH-1:0] count_in;
  logic overflow_in;
  logic locked;
  logic err_val;
  logic err_ovf;
  logic [STAT_W-1:0] err_count;
  logic [STAT_W-1:0] wrap_count;
  modport master (
    output en, clear, count_in, overflow_in,
    input locked, err_val, err_ovf, err_count, wrap_count
  );
  modport slave (
    input en, clear, count_in, overflow_in,
    output locked, err_val, err_ovf, err_count, wrap_count
  );
endinterface

// File: rtl/counter_checker_sat_counter.sv
// sat_counter: statistics counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else if (clr) r_q <= '0;
    else if (inc && !(&r_q)) r_q <= r_q + W'(1);
  end
  assign q = r_q;
endmodule

// File: rtl/counter_checker.sv
// counter_checker: locks onto a +1 counter stream and flags value/overflow mismatches.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SYNC_LEN = 4,
  parameter int STAT_W = DEF_STAT_W
) (
  input logic clk,
  input logic rst,
  counter_checker_if.slave bus
);
  localparam int SYNC_W = $clog2(SYNC_LEN + 1);
  logic [WIDTH-1:0] r_cnt1, r_prev, w_prev_nxt, w_exp;
  logic r_ovf1, r_en1;
  chk_state_e r_state, w_state_nxt;
  logic [SYNC_W-1:0] r_sync, w_sync_nxt;
  logic w_vmis, w_omis, w_ev, w_eo, w_wr;
  logic r_ev2, r_eo2, r_wr2;
  logic r_locked, r_err_val, r_err_ovf;
  logic [STAT_W-1:0] w_err_count, w_wrap_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt1 <= '0;
      r_ovf1 <= 1'b0;
      r_en1 <= 1'b0;
    end else begin
      r_cnt1 <= bus.count_in;
      r_ovf1 <= bus.overflow_in;
      r_en1 <= bus.en;
    end
  end

  assign w_exp = WIDTH'(next_val(64'(r_prev), WIDTH));
  assign w_vmis = r_cnt1 != w_exp;
  assign w_omis = r_ovf1 != (&r_cnt1);

  // en travels with its sample, so a disabled sample always returns the checker to IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt = r_prev;
    w_sync_nxt = r_sync;
    w_ev = 1'b0;
    w_eo = 1'b0;
    w_wr = 1'b0;
    if (!r_en1) begin
      w_state_nxt = IDLE;
      w_sync_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = ACQUIRE;
          w_prev_nxt = r_cnt1;
          w_sync_nxt = '0;
        end
        ACQUIRE: begin
          w_prev_nxt = r_cnt1;
          w_sync_nxt = w_vmis ? '0 : r_sync + SYNC_W'(1);
          w_state_nxt = (!w_vmis && (32'(r_sync) + 1 == SYNC_LEN)) ? LOCKED : ACQUIRE;
        end
        LOCKED: begin
          w_prev_nxt = r_cnt1;
          w_ev = w_vmis;
          w_eo = w_omis;
          w_wr = !w_vmis && (&r_prev);
          w_state_nxt = w_vmis ? ACQUIRE : LOCKED;
          w_sync_nxt = w_vmis ? '0 : r_sync;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev <= '0;
      r_sync <= '0;
      r_ev2 <= 1'b0;
      r_eo2 <= 1'b0;
      r_wr2 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev <= w_prev_nxt;
      r_sync <= w_sync_nxt;
      r_ev2 <= w_ev;
      r_eo2 <= w_eo;
      r_wr2 <= w_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked <= 1'b0;
      r_err_val <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_locked <= r_state == LOCKED;
      r_err_val <= r_ev2;
      r_err_ovf <= r_eo2;
    end
  end

  sat_counter #(.W(STAT_W)) u_err_count (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(r_ev2 | r_eo2), .q(w_err_count)
  );

  sat_counter #(.W(STAT_W)) u_wrap_count (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(r_wr2), .q(w_wrap_count)
  );

  assign bus.locked = r_locked;
  assign bus.err_val = r_err_val;
  assign bus.err_ovf = r_err_ovf;
  assign bus.err_count = w_err_count;
  assign bus.wrap_count = w_wrap_count;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: random and directed counter streams against a sample-level reference model.
module tb_counter_checker;
  localparam int W = 8;
  localparam int SL = 4;
  localparam int SW = 2;
  localparam int MAXS = (1 << SW) - 1;
  localparam int TOP = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  counter_checker_if #(.WIDTH(W), .STAT_W(SW)) bus ();
  counter_checker #(.WIDTH(W), .SYNC_LEN(SL), .STAT_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct { bit lk; bit ev; bit eo; bit wr; } res_t;
  typedef struct { bit lk; bit ev; bit eo; int ec; int wc; } exp_t;
  exp_t sb[$];
  res_t pend[$];
  int total = 0, bad = 0;
  int m_mode, m_prev, m_run, m_ec, m_wc, c;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_ec = 0; m_wc = 0;
    sb.delete();
    pend.delete();
    repeat (2) pend.push_back('{0, 0, 0, 0});
  endtask

  // mode 0: not checking, 1: hunting for a run of SL good steps, 2: locked
  task automatic model_step(input bit en, input int cnt, input bit ovf, output res_t r);
    bit good;
    r = '{0, 0, 0, 0};
    good = cnt == (m_prev + 1) % (TOP + 1);
    if (!en) begin
      m_mode = 0; m_run = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_prev = cnt; m_run = 0;
    end else begin
      if (m_mode == 2) begin
        r.ev = !good;
        r.eo = ovf != (cnt == TOP);
        r.wr = good && cnt == 0;
        if (!good) begin m_mode = 1; m_run = 0; end
      end else begin
        m_run = good ? m_run + 1 : 0;
        if (m_run == SL) m_mode = 2;
      end
      m_prev = cnt;
    end
    r.lk = m_mode == 2;
  endtask

  task automatic drive(input bit en, input int cnt, input bit ovf, input bit clr);
    res_t r, e;
    @(negedge clk);
    bus.en = en; bus.count_in = W'(cnt); bus.overflow_in = ovf; bus.clear = clr;
    model_step(en, cnt, ovf, r);
    pend.push_back(r);
    e = pend.pop_front();
    m_ec = clr ? 0 : ((e.ev || e.eo) && m_ec < MAXS) ? m_ec + 1 : m_ec;
    m_wc = clr ? 0 : (e.wr && m_wc < MAXS) ? m_wc + 1 : m_wc;
    sb.push_back('{e.lk, e.ev, e.eo, m_ec, m_wc});
  endtask

  task automatic step(input bit clr = 1'b0);
    drive(1, c, c == TOP, clr);
    c = (c + 1) % (TOP + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_locked", bus.locked, 0);
    chk("rst_err_val", bus.err_val, 0);
    chk("rst_err_ovf", bus.err_ovf, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_wrap_count", bus.wrap_count, 0);
    model_reset();
    bus.en = 1'b0; bus.clear = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("locked", bus.locked, x.lk);
      chk("err_val", bus.err_val, x.ev);
      chk("err_ovf", bus.err_ovf, x.eo);
      chk("err_count", bus.err_count, x.ec);
      chk("wrap_count", bus.wrap_count, x.wc);
    end
  end

  initial begin
    bus.en = 1'b0; bus.clear = 1'b0; bus.count_in = '0; bus.overflow_in = 1'b0;
    do_reset();
    repeat (3) drive(0, 0, 0, 0);
    c = 0;
    repeat (277) step();
    while (c != 8'h35) step();
    drive(1, 8'h37, 0, 0); c = 8'h38;
    repeat (8) step();
    while (c != TOP) step();
    drive(1, TOP, 0, 0); c = 0;
    repeat (6) step();
    drive(1, 8'h10, 1, 0); c = 8'h11;
    repeat (6) step();
    repeat (5) begin
      drive(1, (c + 2) % (TOP + 1), 0, 0); c = (c + 3) % (TOP + 1);
      repeat (6) step();
    end
    drive(1, (c + 5) % (TOP + 1), 0, 0); c = (c + 6) % (TOP + 1);
    step();
    step(1'b1);
    repeat (6) step();
    repeat (2) begin
      drive(1, (c + 9) % (TOP + 1), 0, 0); c = (c + 10) % (TOP + 1);
      repeat (6) step();
    end
    do_reset();
    repeat (2) drive(0, 0, 0, 0);
    repeat (30) step();
    for (int i = 0; i < 3000; i++) begin
      int k, v;
      bit clr;
      k = $urandom_range(0, 99);
      clr = $urandom_range(0, 39) == 0;
      if (k < 3) begin
        v = (c + $urandom_range(2, TOP)) % (TOP + 1);
        drive(1, v, 1'($urandom_range(0, 1)), clr);
        c = (v + 1) % (TOP + 1);
      end else if (k < 6) begin
        drive(1, c, c != TOP, clr);
        c = (c + 1) % (TOP + 1);
      end else if (k < 7) begin
        repeat ($urandom_range(1, 3)) drive(0, $urandom_range(0, TOP), 1'($urandom_range(0, 1)), clr);
        c = $urandom_range(0, TOP);
      end else begin
        step(clr);
      end
    end
    repeat (3) drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
